// File: rtl/elastic_pipe_stage_pkg.sv
// pipe_pkg: shared statistic type, saturation limit and modulo pointer increment
// for elastic_pipe_stage.
package pipe_pkg;

    typedef logic [31:0] stat_t;

    localparam stat_t STAT_MAX = 32'hFFFF_FFFF;

    // Compare-and-clear wrap so non-power-of-two depths cycle correctly.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/elastic_pipe_stage_ring_ptr.sv
// ring_ptr: modulo-DEPTH pointer with synchronous clear and increment,
// used for the read and write sides of elastic_pipe_stage.
module ring_ptr
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_ptr <= '0;
        else if (i_inc) r_ptr <= W'(ptr_inc(32'(r_ptr), 32'(DEPTH)));
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: valid/ready pipeline register holding up to DEPTH beats,
// zero payload when empty. Define ELASTIC_PIPE_STATS_EN for stall/full/flush counters.
module elastic_pipe_stage
    import pipe_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
`ifdef ELASTIC_PIPE_STATS_EN
    ,
    output stat_t             stall_cycles,
    output stat_t             full_cycles,
    output stat_t             flush_count
`endif
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic              w_full;
    logic              w_accept;
    logic              w_deliver;

    assign w_full    = r_count == CNT_W'(DEPTH);
    assign in_ready  = !RST && !w_full;
    assign out_valid = r_count != '0;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid && out_ready;
    assign out_data  = out_valid ? r_mem[w_rd_ptr] : '0;
    assign count     = r_count;

    ring_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_rd_ptr (
        .i_clk(CLK),
        .i_rst(RST),
        .i_clr(flush),
        .i_inc(w_deliver),
        .o_ptr(w_rd_ptr)
    );

    ring_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_wr_ptr (
        .i_clk(CLK),
        .i_rst(RST),
        .i_clr(flush),
        .i_inc(w_accept),
        .o_ptr(w_wr_ptr)
    );

    always_ff @(posedge CLK) begin
        if (RST || flush) r_count <= '0;
        else r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_deliver);
    end

    // Storage is deliberately left unreset; count gates everything read from it.
    always_ff @(posedge CLK) begin
        if (w_accept && !flush) r_mem[w_wr_ptr] <= in_data;
    end

`ifdef ELASTIC_PIPE_STATS_EN
    stat_t r_stall;
    stat_t r_full;
    stat_t r_flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall <= '0;
            r_full  <= '0;
            r_flush <= '0;
        end else begin
            if (out_valid && !out_ready && r_stall != STAT_MAX) r_stall <= r_stall + 32'd1;
            if (w_full && r_full != STAT_MAX) r_full <= r_full + 32'd1;
            if (flush && r_flush != STAT_MAX) r_flush <= r_flush + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
    assign full_cycles  = r_full;
    assign flush_count  = r_flush;
`endif

endmodule
